reaction_timer: RTL and testbench
=================================

Name: reaction_timer

Overview:
Downstream consumer of the start-light shift-register FSM's 8-bit light pattern.
- Watches the pattern fill to all-on, then detects "lights out" (all-on to zero).
- Measures driver reaction time in milliseconds from lights-out to the first button rising edge.
- Flags a false start if the button is pressed while the lights are filling or fully lit.
- Result feeds the display and 7-segment path.

Parameters:
- LIGHT_WIDTH, 8, width of the light pattern input; all-on = all ones.
- CNT_WIDTH, 16, width of the reaction-time counter and result.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset: synchronous, active-high; single clock domain.
- lights  input  LIGHT_WIDTH  light pattern from the upstream light FSM (0x00, 0x01, 0x03 … 0xFF, 0x00).
- ms_tick  input  1  one-cycle pulse per millisecond from the clock-tick divider.
- btn  input  1  driver button, already synchronised and debounced, level-sensitive.
- time_ms  output  CNT_WIDTH  captured reaction time in ms; valid while valid=1.
- valid  output  1  result available (held).
- false_start  output  1  sticky false-start flag.
- busy  output  1  high in FILLING, ARMED and TIMING.

Behaviour:
- Reset (synchronous, rst=1 at posedge clk):
  - state=IDLE, count=0, time_ms=0, valid=0, false_start=0, btn_q=0.
  - Takes effect mid-operation from any state; no partial result survives.
- Button edge:
  - btn_q registers btn; press = btn & ~btn_q.
  - A button held across state changes never counts as a press; only rising edges count.
- All outputs are registered. valid/false_start assert the cycle after the qualifying event.
- States and transitions:
  - IDLE:
    - lights != 0 → FILLING; clear valid and false_start on this transition.
  - FILLING:
    - press → FAULT (takes priority).
    - else lights == all-ones → ARMED.
    - else lights == 0 (aborted sequence) → IDLE.
  - ARMED:
    - press → FAULT (takes priority over lights-out in the same cycle).
    - else lights == 0 → TIMING, count <= 0.
    - Any other non-zero pattern → FILLING.
  - TIMING:
    - ms_tick → count <= count+1, saturating at 2^CNT_WIDTH-1; no wrap.
    - press → DONE, time_ms <= count + (ms_tick ? 1 : 0), saturated; valid <= 1.
  - DONE:
    - Hold time_ms and valid.
    - lights != 0 → FILLING; clear valid and zero time_ms.
    - Further presses are ignored.
  - FAULT:
    - false_start=1, time_ms=0, valid=0.
    - Presses are ignored.
    - Wait for lights == 0 → IDLE; false_start stays set until the next IDLE→FILLING transition.
- A press in the same cycle as lights-out (ARMED) is a false start.
- A press in the cycle after entering TIMING gives time_ms = 0, or 1 if ms_tick coincides.
- ms_tick is ignored outside TIMING.

Decomposition:
- Package reaction_pkg:
  - state enum (IDLE, FILLING, ARMED, TIMING, DONE, FAULT).
  - LIGHT_WIDTH and CNT_WIDTH defaults.
  - ALL_ON constant.
- Sub-module edge_detect: rising-edge detector on btn, one register plus an AND gate; reused for other button inputs.
- Saturating counter stays inline.

Test Plan:
- Reset mid-sequence: drive lights 0x07, assert rst one cycle → state IDLE, time_ms=0, valid=0, false_start=0, busy=0.
- Normal run: lights step 0x01…0xFF then 0x00, 250 ms_ticks, then btn rises → time_ms=250, valid=1 the next cycle, busy=0.
- False start while lit: btn rises while lights=0xFF → false_start=1, valid=0, time_ms=0; then lights 0x00 → IDLE; then lights 0x01 → false_start cleared.
- Held button: btn high from IDLE through lights-out, released, pressed after 40 ticks → no fault, time_ms=40.
- Saturation: CNT_WIDTH=4, 20 ticks in TIMING, then press → time_ms=15; coincident tick and press at count=3 → time_ms=4.
- Abort and rerun: lights 0x03 → 0x00 → IDLE with no result; a full new sequence with a press after 7 ticks → time_ms=7; a later lights=0x01 clears valid.

Source files
------------

// File: rtl/reaction_pkg.sv
// Shared types and defaults for the reaction timer slice.
package reaction_pkg;

    localparam int unsigned LIGHT_WIDTH_DEF = 8;
    localparam int unsigned CNT_WIDTH_DEF   = 16;

    localparam logic [LIGHT_WIDTH_DEF-1:0] ALL_ON = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILLING,
        ST_ARMED,
        ST_TIMING,
        ST_DONE,
        ST_FAULT
    } state_t;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for a synchronised, debounced level input.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q;
    logic d_d;

    always_comb begin
        d_d = d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/reaction_timer.sv
// Measures driver reaction time from lights-out to button press; flags false starts.
module reaction_timer
    import reaction_pkg::*;
#(
    parameter int unsigned LIGHT_WIDTH = LIGHT_WIDTH_DEF,
    parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LIGHT_WIDTH-1:0] lights,
    input  logic                   ms_tick,
    input  logic                   btn,
    output logic [CNT_WIDTH-1:0]   time_ms,
    output logic                   valid,
    output logic                   false_start,
    output logic                   busy
);

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic [CNT_WIDTH-1:0]   time_q, time_d;
    logic                   valid_q, valid_d;
    logic                   fs_q, fs_d;
    logic                   busy_q, busy_d;
    logic                   press;
    logic                   lights_zero;
    logic                   lights_full;
    logic [CNT_WIDTH-1:0]   count_inc;

    edge_detect u_btn_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (btn),
        .rise (press)
    );

    assign lights_zero = (lights == '0);
    assign lights_full = (lights == {LIGHT_WIDTH{1'b1}});
    assign count_inc   = (count_q == {CNT_WIDTH{1'b1}}) ? count_q : count_q + CNT_WIDTH'(1);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        time_d  = time_q;
        valid_d = valid_q;
        fs_d    = fs_q;

        unique case (state_q)
            ST_IDLE: begin
                if (!lights_zero) begin
                    state_d = ST_FILLING;
                    valid_d = 1'b0;
                    fs_d    = 1'b0;
                end
            end
            ST_FILLING: begin
                if (press) begin
                    state_d = ST_FAULT;
                end else if (lights_full) begin
                    state_d = ST_ARMED;
                end else if (lights_zero) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                // A press coinciding with lights-out is still a false start.
                if (press) begin
                    state_d = ST_FAULT;
                end else if (lights_zero) begin
                    state_d = ST_TIMING;
                    count_d = '0;
                end else if (!lights_full) begin
                    state_d = ST_FILLING;
                end
            end
            ST_TIMING: begin
                if (ms_tick) begin
                    count_d = count_inc;
                end
                if (press) begin
                    state_d = ST_DONE;
                    time_d  = ms_tick ? count_inc : count_q;
                    valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (!lights_zero) begin
                    state_d = ST_FILLING;
                    valid_d = 1'b0;
                    time_d  = '0;
                end
            end
            ST_FAULT: begin
                if (lights_zero) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_FAULT) begin
            fs_d    = 1'b1;
            time_d  = '0;
            valid_d = 1'b0;
        end

        busy_d = (state_d == ST_FILLING) || (state_d == ST_ARMED) || (state_d == ST_TIMING);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            time_q  <= '0;
            valid_q <= 1'b0;
            fs_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            time_q  <= time_d;
            valid_q <= valid_d;
            fs_q    <= fs_d;
            busy_q  <= busy_d;
        end
    end

    assign time_ms     = time_q;
    assign valid       = valid_q;
    assign false_start = fs_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench: default-width timer plus a 4-bit counter instance for saturation.
module tb_reaction_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  lights;
    logic        ms_tick;
    logic        btn;
    logic [15:0] time_ms;
    logic        valid;
    logic        false_start;
    logic        busy;

    logic [7:0]  l2;
    logic        t2;
    logic        b2;
    logic [3:0]  time2;
    logic        valid2;
    logic        fs2;
    logic        busy2;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    reaction_timer #(.LIGHT_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .lights      (lights),
        .ms_tick     (ms_tick),
        .btn         (btn),
        .time_ms     (time_ms),
        .valid       (valid),
        .false_start (false_start),
        .busy        (busy)
    );

    reaction_timer #(.LIGHT_WIDTH(8), .CNT_WIDTH(4)) dut_sat (
        .clk         (clk),
        .rst         (rst),
        .lights      (l2),
        .ms_tick     (t2),
        .btn         (b2),
        .time_ms     (time2),
        .valid       (valid2),
        .false_start (fs2),
        .busy        (busy2)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Steps the pattern 0x01, 0x03 ... 0xFF, one value per cycle.
    task automatic fill(input bit sat);
        logic [8:0] p;
        for (int i = 1; i <= 8; i++) begin
            p = (9'd1 << i) - 9'd1;
            if (sat) l2 = p[7:0];
            else     lights = p[7:0];
            cyc();
        end
    endtask

    initial begin
        rst = 1'b1; lights = '0; ms_tick = 1'b0; btn = 1'b0;
        l2 = '0; t2 = 1'b0; b2 = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        chk("por_valid", valid, 0);
        chk("por_time", time_ms, 0);

        // Reset mid-sequence
        lights = 8'h01; cyc();
        lights = 8'h03; cyc();
        lights = 8'h07; cyc();
        chk("mid_busy_before", busy, 1);
        rst = 1'b1; cyc();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_fs", false_start, 0);
        chk("rst_time", time_ms, 0);
        lights = 8'h00; cyc();
        chk("rst_idle_busy", busy, 0);

        // Normal run: 250 ticks
        fill(1'b0);
        chk("armed_busy", busy, 1);
        lights = 8'h00; cyc();
        ms_tick = 1'b1;
        repeat (250) cyc();
        ms_tick = 1'b0; btn = 1'b1; cyc();
        chk("run_time", time_ms, 250);
        chk("run_valid", valid, 1);
        chk("run_busy", busy, 0);
        chk("run_fs", false_start, 0);
        btn = 1'b0; cyc();
        btn = 1'b1; ms_tick = 1'b1; cyc();
        ms_tick = 1'b0;
        chk("done_ignore_press", time_ms, 250);
        chk("done_hold_valid", valid, 1);
        btn = 1'b0;

        // False start while fully lit
        lights = 8'h01; cyc();
        chk("refill_valid_clr", valid, 0);
        chk("refill_time_clr", time_ms, 0);
        fill(1'b0);
        btn = 1'b1; cyc();
        chk("fs_set", false_start, 1);
        chk("fs_valid", valid, 0);
        chk("fs_time", time_ms, 0);
        btn = 1'b0; cyc();
        chk("fault_busy", busy, 0);
        lights = 8'h00; cyc();
        chk("fs_sticky_idle", false_start, 1);
        lights = 8'h01; cyc();
        chk("fs_cleared", false_start, 0);
        chk("fs_refill_busy", busy, 1);

        // Press coincident with lights-out is a false start
        fill(1'b0);
        lights = 8'h00; btn = 1'b1; cyc();
        chk("coincide_fs", false_start, 1);
        chk("coincide_valid", valid, 0);
        btn = 1'b0; cyc();
        chk("coincide_idle_busy", busy, 0);

        // Held button from IDLE through lights-out
        btn = 1'b1; cyc(); cyc();
        fill(1'b0);
        lights = 8'h00; cyc();
        chk("held_no_fault", false_start, 0);
        chk("held_timing_busy", busy, 1);
        btn = 1'b0; cyc();
        ms_tick = 1'b1;
        repeat (40) cyc();
        ms_tick = 1'b0; btn = 1'b1; cyc();
        chk("held_time", time_ms, 40);
        chk("held_valid", valid, 1);
        chk("held_fs", false_start, 0);
        btn = 1'b0;

        // Abort and rerun
        lights = 8'h03; cyc();
        lights = 8'h00; cyc();
        chk("abort_busy", busy, 0);
        chk("abort_valid", valid, 0);
        chk("abort_time", time_ms, 0);
        fill(1'b0);
        lights = 8'h00; cyc();
        ms_tick = 1'b1;
        repeat (7) cyc();
        ms_tick = 1'b0; btn = 1'b1; cyc();
        chk("rerun_time", time_ms, 7);
        chk("rerun_valid", valid, 1);
        btn = 1'b0; cyc();
        lights = 8'h01; cyc();
        chk("rerun_valid_clr", valid, 0);
        chk("rerun_time_clr", time_ms, 0);
        lights = 8'h00; cyc();

        // Immediate press after lights-out with a coincident tick
        fill(1'b0);
        lights = 8'h00; cyc();
        ms_tick = 1'b1; btn = 1'b1; cyc();
        ms_tick = 1'b0;
        chk("immediate_tick_time", time_ms, 1);
        chk("immediate_tick_valid", valid, 1);
        btn = 1'b0;

        // Saturation with a 4-bit counter
        fill(1'b1);
        l2 = 8'h00; cyc();
        t2 = 1'b1;
        repeat (20) cyc();
        t2 = 1'b0; b2 = 1'b1; cyc();
        chk("sat_time", time2, 15);
        chk("sat_valid", valid2, 1);
        b2 = 1'b0; cyc();
        fill(1'b1);
        l2 = 8'h00; cyc();
        t2 = 1'b1;
        repeat (3) cyc();
        b2 = 1'b1; cyc();
        t2 = 1'b0;
        chk("sat_coincide_time", time2, 4);
        chk("sat_coincide_busy", busy2, 0);
        b2 = 1'b0; cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
